// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants: receiver state encoding,
//                frame geometry, divider floor and the empty-read word.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-tracking states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int          UART_DATA_BITS  = 8;
    localparam logic [31:0] UART_MIN_DIV    = 32'd4;
    localparam logic [31:0] UART_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Small circular byte FIFO with extra-MSB pointers. A push
//                into a full FIFO is accepted only when a pop happens in the
//                same cycle; a pop from an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Equal pointers mean empty; same slot but different lap bit means full.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule : uart_byte_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 serial receiver with programmable bit divider, byte
//                FIFO, simpleuart-style divider/data registers and sticky
//                framing/overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 106
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_re,
    output logic [31:0] reg_dat_do,
    output logic        rx_avail,
    output logic        err_frame,
    output logic        err_overrun,
    input  logic        err_clr
);

    logic        r_sync1;
    logic        r_rx_s;
    logic [31:0] r_div;
    logic [31:0] w_div_eff;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] r_div_lat;
    logic [31:0] w_div_lat_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;

    logic        w_push;
    logic        w_frame_set;
    logic        w_overrun_set;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        r_err_frame;
    logic        r_err_overrun;

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= ser_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // Divider register with independent byte-lane writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div <= 32'(DEFAULT_DIV);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
            end
        end
    end

    // Very small dividers cannot centre the sample point, so clamp them.
    assign w_div_eff = (r_div < UART_MIN_DIV) ? UART_MIN_DIV : r_div;

    // Frame FSM state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div_lat <= 32'(DEFAULT_DIV);
            r_shift   <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_lat <= w_div_lat_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    // Frame FSM next-state: half-bit to mid start, then one bit per sample.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_lat_nxt = r_div_lat;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_push        = 1'b0;
        w_frame_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt   = START;
                    w_div_lat_nxt = w_div_eff;
                    w_cnt_nxt     = (w_div_eff >> 1) - 32'd1;
                end
            end
            START: begin
                if (r_cnt == 32'd0) begin
                    if (!r_rx_s) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = r_div_lat - 32'd1;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            DATA: begin
                if (r_cnt == 32'd0) begin
                    w_shift_nxt[r_idx] = r_rx_s;
                    w_cnt_nxt          = r_div_lat - 32'd1;
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            STOP: begin
                if (r_cnt == 32'd0) begin
                    if (r_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            BREAK: begin
                if (r_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    uart_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (reg_dat_re),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A full FIFO only loses a byte when nothing is popped that same cycle.
    assign w_overrun_set = w_push && w_full && !reg_dat_re;

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_frame   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_frame_set)   r_err_frame <= 1'b1;
            else if (err_clr)  r_err_frame <= 1'b0;
            if (w_overrun_set) r_err_overrun <= 1'b1;
            else if (err_clr)  r_err_overrun <= 1'b0;
        end
    end

    assign reg_div_do  = r_div;
    assign reg_dat_do  = w_empty ? UART_EMPTY_WORD : {24'd0, w_head};
    assign rx_avail    = !w_empty;
    assign err_frame   = r_err_frame;
    assign err_overrun = r_err_overrun;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo: reset state,
//                reception, glitch rejection, framing error, overrun, divider
//                changes and reset mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_rx = 1'b1;
    logic [3:0]  reg_div_we = 4'd0;
    logic [31:0] reg_div_di = 32'd0;
    logic [31:0] reg_div_do;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_do;
    logic        rx_avail;
    logic        err_frame;
    logic        err_overrun;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_fifo #(
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (106)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ser_rx      (ser_rx),
        .reg_div_we  (reg_div_we),
        .reg_div_di  (reg_div_di),
        .reg_div_do  (reg_div_do),
        .reg_dat_re  (reg_dat_re),
        .reg_dat_do  (reg_dat_do),
        .rx_avail    (rx_avail),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Whole-run time limit.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One 8N1 frame, LSB first; starts and ends on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input int div, input logic stop_val);
        ser_rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (div) @(negedge clk);
        end
        ser_rx = stop_val;
        repeat (div) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    // Sample the data register, then pulse the read strobe for one cycle.
    task automatic rd(output logic [31:0] v);
        @(negedge clk);
        v = reg_dat_do;
        reg_dat_re = 1'b1;
        @(negedge clk);
        reg_dat_re = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_dat: got 0x%08h, expected 0xffffffff", reg_dat_do); end
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL reset_avail: got %b, expected 0", rx_avail); end
        n_cmp++; if (reg_div_do !== 32'd106) begin n_bad++; $display("FAIL reset_div: got %0d, expected 106", reg_div_do); end
        n_cmp++; if (err_frame !== 1'b0) begin n_bad++; $display("FAIL reset_err_frame: got %b, expected 0", err_frame); end
        n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_err_overrun: got %b, expected 0", err_overrun); end
    endtask

    task automatic test_two_bytes();
        logic [31:0] v;
        int   cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        @(negedge clk);
        fork
            begin
                send_byte(8'h55, 106, 1'b1);
                send_byte(8'hA3, 106, 1'b1);
            end
            begin
                while (rx_avail !== 1'b1 && cyc < 1100) begin
                    @(negedge clk);
                    cyc++;
                end
                seen = rx_avail;
            end
        join
        n_cmp++; if (seen !== 1'b1 || cyc > 1010 || cyc < 960) begin n_bad++; $display("FAIL avail_latency: got %0d cycles (seen=%b), required 960..1010", cyc, seen); end
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_0055) begin n_bad++; $display("FAIL rx_0x55: got 0x%08h, expected 0x00000055", v); end
        rd(v); n_cmp++; if (v !== 32'h0000_00A3) begin n_bad++; $display("FAIL rx_0xA3: got 0x%08h, expected 0x000000a3", v); end
        rd(v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rx_empty: got 0x%08h, expected 0xffffffff", v); end
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL rx_avail_drained: got %b, expected 0", rx_avail); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (30) @(negedge clk);
        ser_rx = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL glitch_avail: got %b, expected 0", rx_avail); end
        n_cmp++; if (err_frame !== 1'b0) begin n_bad++; $display("FAIL glitch_err: got %b, expected 0", err_frame); end
        send_byte(8'h5A, 106, 1'b1);
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_005A) begin n_bad++; $display("FAIL glitch_then_0x5A: got 0x%08h, expected 0x0000005a", v); end
    endtask

    task automatic test_frame_error();
        logic [31:0] v;
        @(negedge clk);
        send_byte(8'h3C, 106, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++; if (err_frame !== 1'b1) begin n_bad++; $display("FAIL frame_err_set: got %b, expected 1", err_frame); end
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL frame_err_empty: got %b, expected 0", rx_avail); end
        send_byte(8'h41, 106, 1'b1);
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_0041) begin n_bad++; $display("FAIL frame_err_then_0x41: got 0x%08h, expected 0x00000041", v); end
        n_cmp++; if (err_frame !== 1'b1) begin n_bad++; $display("FAIL frame_err_sticky: got %b, expected 1", err_frame); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++; if (err_frame !== 1'b0) begin n_bad++; $display("FAIL frame_err_clr: got %b, expected 0", err_frame); end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 106, 1'b1);
        repeat (5) @(negedge clk);
        n_cmp++; if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b, expected 1", err_overrun); end
        for (int i = 1; i <= 4; i++) begin
            rd(v);
            n_cmp++; if (v !== 32'(i)) begin n_bad++; $display("FAIL overrun_read%0d: got 0x%08h, expected 0x%08h", i, v, 32'(i)); end
        end
        rd(v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL overrun_drained: got 0x%08h, expected 0xffffffff", v); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clr: got %b, expected 0", err_overrun); end
        // Refill, then pop exactly on the cycle the fifth stop bit is sampled.
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 106, 1'b1);
        fork
            send_byte(8'h05, 106, 1'b1);
            begin
                repeat (1009) @(negedge clk);
                reg_dat_re = 1'b1;
                @(negedge clk);
                reg_dat_re = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_pop_same_cycle: got %b, expected 0", err_overrun); end
        for (int i = 2; i <= 5; i++) begin
            rd(v);
            n_cmp++; if (v !== 32'(i)) begin n_bad++; $display("FAIL overrun_pop_read%0d: got 0x%08h, expected 0x%08h", i, v, 32'(i)); end
        end
    endtask

    task automatic test_divider();
        logic [31:0] v;
        @(negedge clk);
        fork
            send_byte(8'h7E, 106, 1'b1);
            begin
                repeat (300) @(negedge clk);
                reg_div_di = 32'd54;
                reg_div_we = 4'b0001;
                @(negedge clk);
                reg_div_we = 4'b0000;
            end
        join
        n_cmp++; if (reg_div_do !== 32'd54) begin n_bad++; $display("FAIL div_write54: got %0d, expected 54", reg_div_do); end
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_007E) begin n_bad++; $display("FAIL div_midframe_0x7E: got 0x%08h, expected 0x0000007e", v); end
        send_byte(8'h81, 54, 1'b1);
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_0081) begin n_bad++; $display("FAIL div54_0x81: got 0x%08h, expected 0x00000081", v); end
        reg_div_di = 32'd1;
        reg_div_we = 4'b1111;
        @(negedge clk);
        reg_div_we = 4'b0000;
        n_cmp++; if (reg_div_do !== 32'd1) begin n_bad++; $display("FAIL div_write1: got %0d, expected 1", reg_div_do); end
        repeat (2) @(negedge clk);
        send_byte(8'hC3, 4, 1'b1);
        repeat (3) @(negedge clk);
        rd(v); n_cmp++; if (v !== 32'h0000_00C3) begin n_bad++; $display("FAIL div_clamp_0xC3: got 0x%08h, expected 0x000000c3", v); end
        reg_div_di = 32'd106;
        reg_div_we = 4'b1111;
        @(negedge clk);
        reg_div_we = 4'b0000;
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        fork
            send_byte(8'hFF, 106, 1'b1);
            begin
                repeat (500) @(negedge clk);
                resetn = 1'b0;
                repeat (2) @(negedge clk);
                resetn = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL midreset_avail: got %b, expected 0", rx_avail); end
        n_cmp++; if (err_frame !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b, expected 0", err_frame); end
        n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midreset_dat: got 0x%08h, expected 0xffffffff", reg_dat_do); end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_divider();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
